// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer, the memory handshake and the datapath.
// The sequencer takes the master view; the datapath (or a bench) takes the slave view.
interface control_sequencer_if #(
    parameter int OPW = 5
);
    logic           Run;
    logic [31:0]    IR;
    logic           Mem_ready;

    logic           PCout;
    logic           PCin;
    logic           IncPC;
    logic           MARin;
    logic           Read;
    logic           MDRin;
    logic           MDRout;
    logic           IRin;
    logic           Yin;
    logic           ZLowIn;
    logic           ZHighIn;
    logic           Zlowout;
    logic           ZHighout;
    logic           HIin;
    logic           LOin;
    logic           Rout;
    logic           Rin;
    logic [3:0]     Rsel_out;
    logic [3:0]     Rsel_in;
    logic [OPW-1:0] ALU_op;
    logic           Done;
    logic           Illegal;
    logic           Mem_fault;

    modport master (
        input  Run, IR, Mem_ready,
        output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
               Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin,
               Rout, Rin, Rsel_out, Rsel_in, ALU_op, Done, Illegal, Mem_fault
    );

    modport slave (
        output Run, IR, Mem_ready,
        input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
               Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin,
               Rout, Rin, Rsel_out, Rsel_in, ALU_op, Done, Illegal, Mem_fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer (T0..T6) producing the datapath control strobes.
// Strobes are decoded from the current state and held for the whole state cycle.
module control_sequencer #(
    parameter int OPW        = 5,
    parameter int WAIT_LIMIT = 8
) (
    input  logic                 Clock,
    input  logic                 Clear,
    control_sequencer_if.master  bus
);
    localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               fault_reg;

    logic [OPW-1:0]     op;
    logic [3:0]         ra;
    logic [3:0]         rb;
    logic [3:0]         rc;
    logic               is_alu;
    logic               is_md;
    logic               is_nop;
    logic               is_halt;
    logic               is_illegal;
    logic               unused_ir;

    assign op = bus.IR[31 -: OPW];
    assign ra = bus.IR[26:23];
    assign rb = bus.IR[22:19];
    assign rc = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    assign is_alu     = (op <= OPW'(8));
    assign is_md      = (op == OPW'(15)) || (op == OPW'(16));
    assign is_nop     = (op == OPW'(26));
    assign is_halt    = (op == OPW'(27));
    assign is_illegal = !(is_alu || is_md || is_nop || is_halt);

    // Run is only consulted here and in IDLE; mid-instruction changes are ignored.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.Run) state_reg <= S_T0;
                end
                S_T0: begin
                    state_reg <= S_T1;
                    cnt_reg   <= '0;
                end
                S_T1: begin
                    // Ready in the final allowed wait cycle still wins over the timeout.
                    if (bus.Mem_ready) begin
                        state_reg <= S_T2;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= S_HALT;
                        fault_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_T2: begin
                    state_reg <= S_T3;
                end
                S_T3: begin
                    if (is_alu || is_md)  state_reg <= S_T4;
                    else if (is_halt)     state_reg <= S_HALT;
                    else                  state_reg <= bus.Run ? S_T0 : S_IDLE;
                end
                S_T4: begin
                    state_reg <= S_T5;
                end
                S_T5: begin
                    if (is_md) state_reg <= S_T6;
                    else       state_reg <= bus.Run ? S_T0 : S_IDLE;
                end
                S_T6: begin
                    state_reg <= bus.Run ? S_T0 : S_IDLE;
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Mem_fault = fault_reg;

    // Clear gates every strobe in its own cycle so an aborted instruction commits nothing.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZLowIn   = 1'b0;
        bus.ZHighIn  = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.ZHighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Rout     = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rsel_out = 4'd0;
        bus.Rsel_in  = 4'd0;
        bus.ALU_op   = '0;
        bus.Done     = 1'b0;
        bus.Illegal  = 1'b0;
        if (!Clear) begin
            case (state_reg)
                S_T0: begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPC = 1'b1;
                    bus.PCin  = 1'b1;
                end
                S_T1: begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                end
                S_T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                S_T3: begin
                    if (is_alu || is_md) begin
                        bus.Rout     = 1'b1;
                        bus.Rsel_out = rb;
                        bus.Yin      = 1'b1;
                    end else begin
                        bus.Done    = 1'b1;
                        bus.Illegal = is_illegal;
                    end
                end
                S_T4: begin
                    bus.Rout     = 1'b1;
                    bus.Rsel_out = rc;
                    bus.ALU_op   = op;
                    bus.ZLowIn   = 1'b1;
                    bus.ZHighIn  = is_md;
                end
                S_T5: begin
                    bus.Zlowout = 1'b1;
                    if (is_md) begin
                        bus.LOin = 1'b1;
                    end else begin
                        bus.Rin     = 1'b1;
                        bus.Rsel_in = ra;
                        bus.Done    = 1'b1;
                    end
                end
                S_T6: begin
                    bus.ZHighout = 1'b1;
                    bus.HIin     = 1'b1;
                    bus.Done     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-by-cycle strobe check of control_sequencer: a vector table plus hand-built corner sequences,
// with expected outputs queued at drive time and popped at the following negative edge.
module tb_control_sequencer;
    typedef struct packed {
        logic       pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
        logic       y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in, r_out, r_in;
        logic [3:0] rsel_out;
        logic [3:0] rsel_in;
        logic [4:0] alu_op;
        logic       done, illegal, mem_fault;
    } outs_t;

    typedef struct {
        logic        clr, run, mr;
        logic [31:0] ir;
        outs_t       exp;
        logic [63:0] tag;
    } vec_t;

    typedef struct {
        outs_t       o;
        logic [63:0] tag;
    } exp_t;

    logic clk;
    logic clr;
    int   n_vec = 0;
    int   n_mis = 0;
    vec_t tbl[$];
    exp_t sb[$];

    control_sequencer_if #(.OPW(5)) cs_if ();

    control_sequencer #(.OPW(5), .WAIT_LIMIT(8)) dut (
        .Clock (clk),
        .Clear (clr),
        .bus   (cs_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic outs_t x_idle();
        outs_t o;
        o = '0;
        return o;
    endfunction
    function automatic outs_t x_t0();
        outs_t o;
        o = '0;
        o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.pc_in = 1'b1;
        return o;
    endfunction
    function automatic outs_t x_t1();
        outs_t o;
        o = '0;
        o.read = 1'b1; o.mdr_in = 1'b1;
        return o;
    endfunction
    function automatic outs_t x_t2();
        outs_t o;
        o = '0;
        o.mdr_out = 1'b1; o.ir_in = 1'b1;
        return o;
    endfunction
    function automatic outs_t x_t3_ops(input logic [3:0] rb);
        outs_t o;
        o = '0;
        o.r_out = 1'b1; o.rsel_out = rb; o.y_in = 1'b1;
        return o;
    endfunction
    function automatic outs_t x_t3_done(input logic ill);
        outs_t o;
        o = '0;
        o.done = 1'b1; o.illegal = ill;
        return o;
    endfunction
    function automatic outs_t x_t4(input logic [3:0] rc, input logic [4:0] op, input logic md);
        outs_t o;
        o = '0;
        o.r_out = 1'b1; o.rsel_out = rc; o.alu_op = op; o.zlow_in = 1'b1; o.zhigh_in = md;
        return o;
    endfunction
    function automatic outs_t x_t5_alu(input logic [3:0] ra);
        outs_t o;
        o = '0;
        o.zlow_out = 1'b1; o.r_in = 1'b1; o.rsel_in = ra; o.done = 1'b1;
        return o;
    endfunction
    function automatic outs_t x_t5_md();
        outs_t o;
        o = '0;
        o.zlow_out = 1'b1; o.lo_in = 1'b1;
        return o;
    endfunction
    function automatic outs_t x_t6();
        outs_t o;
        o = '0;
        o.zhigh_out = 1'b1; o.hi_in = 1'b1; o.done = 1'b1;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.pc_out    = cs_if.PCout;    o.pc_in     = cs_if.PCin;
        o.inc_pc    = cs_if.IncPC;    o.mar_in    = cs_if.MARin;
        o.read      = cs_if.Read;     o.mdr_in    = cs_if.MDRin;
        o.mdr_out   = cs_if.MDRout;   o.ir_in     = cs_if.IRin;
        o.y_in      = cs_if.Yin;      o.zlow_in   = cs_if.ZLowIn;
        o.zhigh_in  = cs_if.ZHighIn;  o.zlow_out  = cs_if.Zlowout;
        o.zhigh_out = cs_if.ZHighout; o.hi_in     = cs_if.HIin;
        o.lo_in     = cs_if.LOin;     o.r_out     = cs_if.Rout;
        o.r_in      = cs_if.Rin;      o.rsel_out  = cs_if.Rsel_out;
        o.rsel_in   = cs_if.Rsel_in;  o.alu_op    = cs_if.ALU_op;
        o.done      = cs_if.Done;     o.illegal   = cs_if.Illegal;
        o.mem_fault = cs_if.Mem_fault;
        return o;
    endfunction

    task automatic add(input logic c, input logic r, input logic m, input logic [31:0] ir,
                       input outs_t e, input logic [63:0] tag);
        vec_t v;
        v.clr = c; v.run = r; v.mr = m; v.ir = ir; v.exp = e; v.tag = tag;
        tbl.push_back(v);
    endtask

    task automatic add_fetch(input logic [31:0] ir);
        add(1'b0, 1'b1, 1'b1, ir, x_t0(), "T0");
        add(1'b0, 1'b1, 1'b1, ir, x_t1(), "T1");
        add(1'b0, 1'b1, 1'b1, ir, x_t2(), "T2");
    endtask

    // One clock cycle: drive inputs after the edge, queue the expectation, check at the falling edge.
    task automatic step(input logic c, input logic r, input logic m, input logic [31:0] ir,
                        input outs_t e, input logic mf, input logic [63:0] tag);
        exp_t x;
        outs_t got;
        @(posedge clk);
        #1;
        clr = c; cs_if.Run = r; cs_if.Mem_ready = m; cs_if.IR = ir;
        x.o = e;
        x.o.mem_fault = mf;
        x.tag = tag;
        sb.push_back(x);
        @(negedge clk);
        got = sample();
        n_vec++;
        if (sb.size() == 0) begin
            n_mis++;
            $display("FAIL %s scoreboard empty got=%h", tag, got);
        end else begin
            x = sb.pop_front();
            if (got !== x.o) begin
                n_mis++;
                $display("FAIL %s got=%h exp=%h", x.tag, got, x.o);
            end else begin
                $display("ok   %s outs=%h", x.tag, got);
            end
        end
    endtask

    initial begin
        logic [31:0] ir_a, ir_mul, ir_div, ir_b8, ir_b9, ir_nop, ir_ill, ir_hlt, ir_w;
        ir_a   = 32'h28918000;
        ir_mul = mk_ir(5'b01111, 4'd7, 4'd8, 4'd9);
        ir_div = mk_ir(5'b10000, 4'd10, 4'd11, 4'd12);
        ir_b8  = mk_ir(5'b01000, 4'd13, 4'd14, 4'd15);
        ir_b9  = mk_ir(5'b01001, 4'd1, 4'd2, 4'd3);
        ir_nop = mk_ir(5'b11010, 4'd5, 4'd5, 4'd5);
        ir_ill = mk_ir(5'b11111, 4'd6, 4'd6, 4'd6);
        ir_hlt = mk_ir(5'b11011, 4'd2, 4'd2, 4'd2);
        ir_w   = mk_ir(5'b00000, 4'd4, 4'd5, 4'd6);

        // Reference ALU instruction, back-to-back, then Run dropped at T5.
        add(1'b0, 1'b0, 1'b1, ir_a, x_idle(), "idle");
        add(1'b0, 1'b1, 1'b1, ir_a, x_idle(), "start");
        add_fetch(ir_a);
        add(1'b0, 1'b1, 1'b1, ir_a, x_t3_ops(4'd2), "T3_alu");
        add(1'b0, 1'b1, 1'b1, ir_a, x_t4(4'd3, 5'b00101, 1'b0), "T4_alu");
        add(1'b0, 1'b1, 1'b1, ir_a, x_t5_alu(4'd1), "T5_alu");
        add_fetch(ir_a);
        add(1'b0, 1'b0, 1'b1, ir_a, x_t3_ops(4'd2), "T3_alu");
        add(1'b0, 1'b0, 1'b1, ir_a, x_t4(4'd3, 5'b00101, 1'b0), "T4_alu");
        add(1'b0, 1'b0, 1'b1, ir_a, x_t5_alu(4'd1), "T5_stop");
        add(1'b0, 1'b0, 1'b1, ir_a, x_idle(), "idle");
        // Chained mul, div, boundary opcodes, nop, illegal.
        add(1'b0, 1'b1, 1'b1, ir_mul, x_idle(), "start");
        add_fetch(ir_mul);
        add(1'b0, 1'b1, 1'b1, ir_mul, x_t3_ops(4'd8), "T3_mul");
        add(1'b0, 1'b1, 1'b1, ir_mul, x_t4(4'd9, 5'b01111, 1'b1), "T4_mul");
        add(1'b0, 1'b1, 1'b1, ir_mul, x_t5_md(), "T5_mul");
        add(1'b0, 1'b1, 1'b1, ir_mul, x_t6(), "T6_mul");
        add_fetch(ir_div);
        add(1'b0, 1'b1, 1'b1, ir_div, x_t3_ops(4'd11), "T3_div");
        add(1'b0, 1'b1, 1'b1, ir_div, x_t4(4'd12, 5'b10000, 1'b1), "T4_div");
        add(1'b0, 1'b1, 1'b1, ir_div, x_t5_md(), "T5_div");
        add(1'b0, 1'b1, 1'b1, ir_div, x_t6(), "T6_div");
        add_fetch(ir_b8);
        add(1'b0, 1'b1, 1'b1, ir_b8, x_t3_ops(4'd14), "T3_op8");
        add(1'b0, 1'b1, 1'b1, ir_b8, x_t4(4'd15, 5'b01000, 1'b0), "T4_op8");
        add(1'b0, 1'b1, 1'b1, ir_b8, x_t5_alu(4'd13), "T5_op8");
        add_fetch(ir_b9);
        add(1'b0, 1'b1, 1'b1, ir_b9, x_t3_done(1'b1), "T3_op9");
        add_fetch(ir_nop);
        add(1'b0, 1'b1, 1'b1, ir_nop, x_t3_done(1'b0), "T3_nop");
        add_fetch(ir_ill);
        add(1'b0, 1'b0, 1'b1, ir_ill, x_t3_done(1'b1), "T3_ill");
        add(1'b0, 1'b0, 1'b1, ir_ill, x_idle(), "idle");
        // Halt opcode: parks until Clear even with Run high.
        add(1'b0, 1'b1, 1'b1, ir_hlt, x_idle(), "start");
        add_fetch(ir_hlt);
        add(1'b0, 1'b1, 1'b1, ir_hlt, x_t3_done(1'b0), "T3_halt");
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, ir_hlt, x_idle(), "halted");

        clr = 1'b1; cs_if.Run = 1'b0; cs_if.Mem_ready = 1'b0; cs_if.IR = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].clr, tbl[i].run, tbl[i].mr, tbl[i].ir, tbl[i].exp, 1'b0, tbl[i].tag);

        // Three wait cycles: Read/MDRin held four cycles, nine cycles in total.
        step(1'b1, 1'b0, 1'b0, ir_w, x_idle(), 1'b0, "clear");
        step(1'b0, 1'b1, 1'b0, ir_w, x_idle(), 1'b0, "start");
        step(1'b0, 1'b1, 1'b0, ir_w, x_t0(), 1'b0, "T0");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, ir_w, x_t1(), 1'b0, "T1_wait");
        step(1'b0, 1'b1, 1'b1, ir_w, x_t1(), 1'b0, "T1_rdy");
        step(1'b0, 1'b1, 1'b0, ir_w, x_t2(), 1'b0, "T2");
        step(1'b0, 1'b1, 1'b0, ir_w, x_t3_ops(4'd5), 1'b0, "T3_alu");
        step(1'b0, 1'b1, 1'b0, ir_w, x_t4(4'd6, 5'b00000, 1'b0), 1'b0, "T4_alu");
        step(1'b0, 1'b0, 1'b0, ir_w, x_t5_alu(4'd4), 1'b0, "T5_stop");
        step(1'b0, 1'b0, 1'b0, ir_w, x_idle(), 1'b0, "idle");

        // Ready arriving in the eighth wait cycle beats the timeout.
        step(1'b0, 1'b1, 1'b0, ir_w, x_idle(), 1'b0, "start");
        step(1'b0, 1'b1, 1'b0, ir_w, x_t0(), 1'b0, "T0");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, ir_w, x_t1(), 1'b0, "T1_wait");
        step(1'b0, 1'b1, 1'b1, ir_w, x_t1(), 1'b0, "T1_last");
        step(1'b0, 1'b1, 1'b0, ir_w, x_t2(), 1'b0, "T2_late");
        step(1'b0, 1'b0, 1'b0, ir_w, x_t3_ops(4'd5), 1'b0, "T3_alu");
        step(1'b0, 1'b0, 1'b0, ir_w, x_t4(4'd6, 5'b00000, 1'b0), 1'b0, "T4_alu");
        step(1'b0, 1'b0, 1'b0, ir_w, x_t5_alu(4'd4), 1'b0, "T5_stop");
        step(1'b0, 1'b0, 1'b0, ir_w, x_idle(), 1'b0, "idle");

        // Memory never ready: HALT with sticky fault until Clear.
        step(1'b0, 1'b1, 1'b0, ir_w, x_idle(), 1'b0, "start");
        step(1'b0, 1'b1, 1'b0, ir_w, x_t0(), 1'b0, "T0");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, ir_w, x_t1(), 1'b0, "T1_wait");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, ir_w, x_idle(), 1'b1, "fault");
        step(1'b1, 1'b1, 1'b1, ir_w, x_idle(), 1'b1, "clear");
        step(1'b0, 1'b0, 1'b1, ir_w, x_idle(), 1'b0, "unfault");

        // Clear during T4 suppresses strobes in that cycle and lands in IDLE.
        step(1'b0, 1'b1, 1'b1, ir_a, x_idle(), 1'b0, "start");
        step(1'b0, 1'b1, 1'b1, ir_a, x_t0(), 1'b0, "T0");
        step(1'b0, 1'b1, 1'b1, ir_a, x_t1(), 1'b0, "T1");
        step(1'b0, 1'b1, 1'b1, ir_a, x_t2(), 1'b0, "T2");
        step(1'b0, 1'b1, 1'b1, ir_a, x_t3_ops(4'd2), 1'b0, "T3_alu");
        step(1'b1, 1'b1, 1'b1, ir_a, x_idle(), 1'b0, "clr_T4");
        step(1'b0, 1'b0, 1'b1, ir_a, x_idle(), 1'b0, "idle");
        step(1'b0, 1'b0, 1'b1, ir_a, x_idle(), 1'b0, "idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
